sync_fifo_core: RTL and testbench

SYNC_FIFO_CORE -- requirements
Module: sync_fifo_core

---
 rtl/sync_fifo_core.sv | 58 +++++
 tb/tb_sync_fifo_core.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with registered read data and wrap-bit pointers.
// full/empty are decoded combinationally from the pointer pair.
module sync_fifo_core #(
   parameter int unsigned SIZE    = 8,
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned PTR_LEN = $clog2(SIZE)
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             w_en,
   input  logic             r_en,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PW = PTR_LEN + 1;

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [WIDTH-1:0] storage [SIZE];
   logic             wr_acc;
   logic             rd_acc;

   // Equal pointers mean empty; same address with opposite wrap bits means full.
   always_comb begin
      empty  = (wr_ptr == rd_ptr);
      full   = (wr_ptr[PTR_LEN] != rd_ptr[PTR_LEN]) &&
               (wr_ptr[PTR_LEN-1:0] == rd_ptr[PTR_LEN-1:0]);
      wr_acc = w_en & ~full;
      rd_acc = r_en & ~empty;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         data_out <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (rd_acc) begin
            rd_ptr   <= rd_ptr + PW'(1);
            data_out <= storage[rd_ptr[PTR_LEN-1:0]];
         end
      end
   end

   // No reset on storage: contents are unreachable while the pointers say empty.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         storage[wr_ptr[PTR_LEN-1:0]] <= data_in;
      end
   end

endmodule

// File: tb/tb_sync_fifo_core.sv
// Bench for sync_fifo_core: directed scenarios plus random traffic,
// checked against a queue-based occupancy/ordering model.
module tb_sync_fifo_core;

   localparam int unsigned SIZE  = 8;
   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             arst_n;
   logic             w_en;
   logic             r_en;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             full;
   logic             empty;

   int n_checks;
   int n_errors;

   logic [WIDTH-1:0] model_q [$];
   logic [WIDTH-1:0] exp_dout;

   sync_fifo_core #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
      .clk      (clk),
      .arst_n   (arst_n),
      .w_en     (w_en),
      .r_en     (r_en),
      .data_in  (data_in),
      .data_out (data_out),
      .full     (full),
      .empty    (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic model_full();
      return model_q.size() == SIZE;
   endfunction

   function automatic logic model_empty();
      return model_q.size() == 0;
   endfunction

   // One clock of traffic; entered and left at a falling edge.
   task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d, input string tag);
      logic wacc, racc;
      w_en    = w;
      r_en    = r;
      data_in = d;
      #1;
      check({tag, "_full_pre"},  32'(full),  32'(model_full()));
      check({tag, "_empty_pre"}, 32'(empty), 32'(model_empty()));
      wacc = w && !model_full();
      racc = r && !model_empty();
      @(posedge clk);
      if (racc) exp_dout = model_q.pop_front();
      if (wacc) model_q.push_back(d);
      @(negedge clk);
      check({tag, "_dout"},  32'(data_out), 32'(exp_dout));
      check({tag, "_full"},  32'(full),     32'(model_full()));
      check({tag, "_empty"}, 32'(empty),    32'(model_empty()));
   endtask

   // Asynchronous reset pulse with traffic held active across edges.
   task automatic do_reset(input int edges, input string tag);
      arst_n  = 1'b0;
      w_en    = 1'b1;
      r_en    = 1'b1;
      data_in = 8'h5A;
      #1;
      model_q.delete();
      exp_dout = '0;
      check({tag, "_rst_empty"}, 32'(empty),    32'd1);
      check({tag, "_rst_full"},  32'(full),     32'd0);
      check({tag, "_rst_dout"},  32'(data_out), 32'd0);
      for (int i = 0; i < edges; i++) begin
         @(negedge clk);
         check({tag, "_rst_hold_empty"}, 32'(empty),    32'd1);
         check({tag, "_rst_hold_dout"},  32'(data_out), 32'd0);
      end
      @(negedge clk);
      w_en   = 1'b0;
      r_en   = 1'b0;
      arst_n = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      exp_dout = '0;
      arst_n   = 1'b1;
      w_en     = 1'b0;
      r_en     = 1'b0;
      data_in  = '0;
      @(negedge clk);

      // Reset with no clock edge needed
      do_reset(2, "init");

      // Read when empty
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, "rd_empty");
      check("rd_empty_dout", 32'(data_out), 32'h00);
      check("rd_empty_flag", 32'(empty), 32'd1);

      // Fill, overflow attempt, drain
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i), "fill");
      check("fill_full", 32'(full), 32'd1);
      step(1'b1, 1'b0, 8'hFF, "overflow");
      check("overflow_full", 32'(full), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 1'b1, 8'h00, "drain");
         check("drain_order", 32'(data_out), 32'(i));
      end
      check("drain_empty", 32'(empty), 32'd1);

      // Wrap-around
      do_reset(1, "wrap");
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 8'(8'h10 + i), "wrap_pair_w");
         step(1'b0, 1'b1, 8'h00, "wrap_pair_r");
         check("wrap_pair_data", 32'(data_out), 32'(8'h10 + i));
      end
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'hA0 + i), "wrap_fill");
      check("wrap_full", 32'(full), 32'd1);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 8'h00, "wrap_drain");
         check("wrap_order", 32'(data_out), 32'(8'hA0 + i));
      end
      check("wrap_empty", 32'(empty), 32'd1);

      // Simultaneous read/write with 3 queued
      do_reset(1, "simul");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h30 + i), "simul_pre");
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 8'(8'h40 + i), "simul");
         check("simul_order", 32'(data_out), 32'(i < 3 ? 8'h30 + i : 8'h40));
         check("simul_occ", 32'(model_q.size()), 32'd3);
         check("simul_flags", 32'({full, empty}), 32'd0);
      end

      // Both requests while empty, then while full
      do_reset(1, "both_edge");
      step(1'b1, 1'b1, 8'hC1, "both_empty");
      check("both_empty_dout", 32'(data_out), 32'h00);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'hC2 + i), "both_fill");
      step(1'b1, 1'b1, 8'hEE, "both_full");
      check("both_full_dout", 32'(data_out), 32'hC1);

      // Mid-operation reset
      do_reset(1, "mid");
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h70 + i), "mid_pre");
      do_reset(0, "mid_pulse");
      step(1'b0, 1'b1, 8'h00, "mid_post");
      check("mid_post_dout", 32'(data_out), 32'h00);

      // Random traffic with phase-varying bias and rare resets
      begin
         int pw, pr;
         pw = 50;
         pr = 50;
         for (int c = 0; c < 2000; c++) begin
            if (c % 100 == 0) begin
               pw = $urandom_range(90, 10);
               pr = $urandom_range(90, 10);
            end
            if ($urandom_range(499, 0) == 0) begin
               do_reset($urandom_range(2, 0), "rnd");
            end else begin
               step(($urandom_range(99, 0) < pw), ($urandom_range(99, 0) < pr),
                    8'($urandom), "rnd");
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
